// File: rtl/kmul_pkg.sv
// Shared widths and helpers for the 256x256 multiplier arbiter.
package kmul_pkg;
  localparam int OP_W   = 256;
  localparam int PROD_W = 512;

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/kmul_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may coincide.
module kmul_sync_fifo
  import kmul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_en  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kmul_arbiter.sv
// Round-robin, credit-limited front end sharing one in-order fixed-latency
// multiplier among NREQ requesters; results return tagged with the owner id.
module kmul_arbiter
  import kmul_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  localparam int ID_W = id_w(NREQ),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_x,
  input  logic [NREQ*OP_W-1:0] req_y,
  output logic [OP_W-1:0]      mul_x,
  output logic [OP_W-1:0]      mul_y,
  output logic                 mul_in_valid,
  input  logic [PROD_W-1:0]    mul_p,
  input  logic                 mul_out_valid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PROD_W-1:0]    rsp_p,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 err_orphan
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; req_ready is combinational from req_valid, rsp_valid is not.
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        cand;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        head_id;
  logic                   found;
  logic                   credit_ok;
  logic                   fire;
  logic                   ret_ok;
  logic                   idq_empty, idq_full;
  logic                   rspq_empty, rspq_full;
  logic [CW-1:0]          idq_count, rspq_count;
  logic [ID_W+PROD_W-1:0] rsp_word;

  // Credits count every issued product until its response is consumed.
  assign credit_ok = (({1'b0, idq_count} + {1'b0, rspq_count}) < (CW+1)'(DEPTH))
                     && !idq_full && !rspq_full;

  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign fire      = reset && found && credit_ok;
  assign req_ready = fire ? (NREQ'(1) << grant_id) : '0;
  assign ret_ok    = mul_out_valid && !idq_empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr       <= '0;
      mul_x        <= '0;
      mul_y        <= '0;
      mul_in_valid <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      mul_in_valid <= fire;
      if (fire) begin
        mul_x  <= req_x[grant_id*OP_W +: OP_W];
        mul_y  <= req_y[grant_id*OP_W +: OP_W];
        rr_ptr <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
      end
      if (mul_out_valid && idq_empty) err_orphan <= 1'b1;
    end
  end

  kmul_sync_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH)) u_idq (
    .clock (clock),
    .reset (reset),
    .push  (fire),
    .pop   (ret_ok),
    .wdata (grant_id),
    .rdata (head_id),
    .count (idq_count),
    .empty (idq_empty),
    .full  (idq_full)
  );

  kmul_sync_fifo #(.WIDTH(ID_W+PROD_W), .DEPTH(DEPTH)) u_rspq (
    .clock (clock),
    .reset (reset),
    .push  (ret_ok),
    .pop   (rsp_ready),
    .wdata ({head_id, mul_p}),
    .rdata (rsp_word),
    .count (rspq_count),
    .empty (rspq_empty),
    .full  (rspq_full)
  );

  assign rsp_valid        = !rspq_empty;
  assign {rsp_id, rsp_p}  = rsp_word;

endmodule

// File: tb/tb_kmul_arbiter.sv
// Randomized bench for kmul_arbiter with a queue-based reference model and a
// behavioural fixed-latency multiplier attached to the issue/product buses.
module tb_kmul_arbiter;
  import kmul_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;
  localparam int ID_W  = 2;
  localparam int W     = ID_W + PROD_W;

  logic                 clock;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*OP_W-1:0] req_x, req_y;
  logic [OP_W-1:0]      mul_x, mul_y;
  logic                 mul_in_valid;
  logic [PROD_W-1:0]    mul_p;
  logic                 mul_out_valid;
  logic                 rsp_valid, rsp_ready;
  logic [PROD_W-1:0]    rsp_p;
  logic [ID_W-1:0]      rsp_id;
  logic                 err_orphan;

  kmul_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_in_valid(mul_in_valid),
    .mul_p(mul_p), .mul_out_valid(mul_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .err_orphan(err_orphan)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard and reference model
  logic [W-1:0]      pend_q[$];
  logic [W-1:0]      res_q[$];
  int                grant_log[$];
  int                rsp_log[$];
  int                rr_m;
  logic              mi_m, err_m;
  logic [OP_W-1:0]   x_m, y_m;
  logic [PROD_W-1:0] last_p;
  logic              pv [LAT];
  logic [PROD_W-1:0] pp [LAT];
  logic              force_out;
  int                checks, fails;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PROD_W-1:0] product(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic [PROD_W-1:0] wa, wb;
    wa = {{OP_W{1'b0}}, a};
    wb = {{OP_W{1'b0}}, b};
    return wa * wb;
  endfunction

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < OP_W/32; j++) begin
        req_x[i*OP_W + j*32 +: 32] = $urandom;
        req_y[i*OP_W + j*32 +: 32] = $urandom;
      end
  endtask

  // One clock cycle: drive the multiplier model, check, update model, step.
  task automatic tick();
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [OP_W-1:0] gx, gy;
    for (int s = LAT-1; s > 0; s--) begin
      pv[s] = pv[s-1];
      pp[s] = pp[s-1];
    end
    pv[0] = mul_in_valid;
    pp[0] = product(mul_x, mul_y);
    mul_out_valid = pv[LAT-1] | force_out;
    mul_p = force_out ? {16{$urandom}} : pp[LAT-1];
    #1;
    check_val("mul_in_valid", W'(mul_in_valid), W'(mi_m));
    check_val("mul_x", W'(mul_x), W'(x_m));
    check_val("mul_y", W'(mul_y), W'(y_m));
    check_val("rsp_valid", W'(rsp_valid), W'(res_q.size() != 0));
    check_val("err_orphan", W'(err_orphan), W'(err_m));
    check_val("idq_count", W'(dut.idq_count), W'(pend_q.size()));
    check_val("rspq_count", W'(dut.rspq_count), W'(res_q.size()));
    g = -1;
    if (reset && (pend_q.size() + res_q.size() < DEPTH))
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    check_val("req_ready", W'(req_ready), W'(exp_ready));
    if (!reset) begin
      pend_q.delete();
      res_q.delete();
      rr_m = 0; mi_m = 1'b0; err_m = 1'b0; x_m = '0; y_m = '0;
    end else begin
      if (rsp_ready && res_q.size() > 0) begin
        check_val("rsp_word", {rsp_id, rsp_p}, res_q.pop_front());
        rsp_log.push_back(int'(rsp_id));
        last_p = rsp_p;
      end
      if (mul_out_valid) begin
        if (pend_q.size() == 0) err_m = 1'b1;
        else res_q.push_back(pend_q.pop_front());
      end
      mi_m = (g >= 0);
      if (g >= 0) begin
        gx = req_x[g*OP_W +: OP_W];
        gy = req_y[g*OP_W +: OP_W];
        pend_q.push_back({ID_W'(g), product(gx, gy)});
        x_m = gx; y_m = gy;
        rr_m = (g + 1) % NREQ;
        grant_log.push_back(g);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
    grant_log.delete();
    rsp_log.delete();
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; fails = 0;
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_x = '0; req_y = '0;
    mul_p = '0; mul_out_valid = 1'b0; force_out = 1'b0;
    for (int s = 0; s < LAT; s++) begin pv[s] = 1'b0; pp[s] = '0; end
    rr_m = 0; mi_m = 1'b0; err_m = 1'b0; x_m = '0; y_m = '0; last_p = '0;
    repeat (2) @(negedge clock);
    do_reset(2);

    // single issue 3*5
    rsp_ready = 1'b1;
    req_x[0 +: OP_W] = OP_W'(3);
    req_y[0 +: OP_W] = OP_W'(5);
    req_valid = 4'b0001;
    tick();
    idle(10);
    check_val("single_grants", W'(grant_log.size()), W'(1));
    check_val("single_rsps", W'(rsp_log.size()), W'(1));
    check_val("single_p", W'(last_p), W'(15));

    // round-robin fairness
    do_reset(1);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin set_ops(); tick(); end
    idle(12);
    check_val("rr_grants", W'(grant_log.size()), W'(8));
    check_val("rr_rsps", W'(rsp_log.size()), W'(8));
    for (int i = 0; i < 8 && i < grant_log.size() && i < rsp_log.size(); i++) begin
      check_val("rr_order", W'(grant_log[i]), W'(i % NREQ));
      check_val("rr_rsp_id", W'(rsp_log[i]), W'(i % NREQ));
    end

    // backpressure against the credit budget
    do_reset(1);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 14; i++) begin set_ops(); tick(); end
    check_val("bp_grants", W'(grant_log.size()), W'(DEPTH));
    check_val("bp_ready", W'(req_ready), W'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("bp_pulse_same", W'(grant_log.size()), W'(DEPTH));
    tick();
    check_val("bp_pulse_next", W'(grant_log.size()), W'(DEPTH + 1));
    repeat (4) tick();
    check_val("bp_pulse_total", W'(grant_log.size()), W'(DEPTH + 1));
    rsp_ready = 1'b1;
    idle(20);

    // 20 back-to-back issues, then random traffic
    do_reset(1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_ops();
      req_valid = NREQ'($urandom_range(1, 15));
      tick();
    end
    idle(12);
    check_val("b2b_grants", W'(grant_log.size()), W'(20));
    check_val("b2b_rsps", W'(rsp_log.size()), W'(20));
    for (int i = 0; i < 300; i++) begin
      set_ops();
      req_valid = NREQ'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rsp_ready = 1'b1;
    idle(20);
    check_val("rand_drained", W'(grant_log.size()), W'(rsp_log.size()));

    // orphan product
    force_out = 1'b1;
    tick();
    force_out = 1'b0;
    idle(5);
    check_val("orphan_flag", W'(err_orphan), W'(1));
    check_val("orphan_no_rsp", W'(rsp_valid), W'(0));
    do_reset(1);
    idle(1);
    check_val("orphan_cleared", W'(err_orphan), W'(0));

    // reset with three operations in flight
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    repeat (3) begin set_ops(); tick(); end
    req_valid = '0;
    do_reset(1);
    tick();
    check_val("mid_rsp_valid", W'(rsp_valid), W'(0));
    check_val("mid_idq_count", W'(dut.idq_count), W'(0));
    check_val("mid_rspq_count", W'(dut.rspq_count), W'(0));
    idle(6);
    check_val("mid_orphan", W'(err_orphan), W'(1));
    check_val("mid_rsp_after", W'(rsp_valid), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
